// File: rtl/group_accum_pkg.sv
// Shared definitions for the group accumulator: the sequence state encoding
// and the output saturation helper.
package group_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // The saturation helper works at this width, so ACC_WIDTH must not exceed it.
  localparam int SAT_W = 64;

  // Clamp a sign-extended value into the signed range of num_width bits.
  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] v,
    input int                      num_width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (num_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/group_accum_fifo.sv
// Two-entry synchronous FIFO. The head entry always lives in e0_q, so the
// output is a plain register and stays stable until it is popped. A push
// into a full FIFO succeeds only if a pop happens in the same cycle;
// otherwise the word is dropped and reported on drop.
module group_accum_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] e0_q;
  logic [WIDTH-1:0] e1_q;
  logic [1:0]       count_q;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign dout    = e0_q;

  // Storage and occupancy; the head is shifted down from e1_q on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage is reset as well because its head drives dout, which
    // must read 0 out of reset; a large RAM would normally be left unreset.
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_q <= din;
          end else begin
            e0_q <= e1_q;
            e1_q <= din;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) e0_q <= din;
          else                 e1_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          e0_q    <= e1_q;
          count_q <= count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/group_accum.sv
// Group accumulator: sums framed signed partial sums from the adder tree,
// rescales the final sum by an arithmetic right shift and narrows it to
// NUM_WIDTH, then queues it in a 2-entry valid/ready buffer.
// Optional build macro GROUP_ACCUM_SATURATE_EN: clamp on narrowing instead
// of taking the low NUM_WIDTH bits.
module group_accum
  import group_accum_pkg::*;
#(
  parameter int NUM_WIDTH   = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   up_val,
  input  logic                   up_first,
  input  logic                   up_last,
  input  logic [NUM_WIDTH-1:0]   up_data,
  output logic                   dn_val,
  input  logic                   dn_rdy,
  output logic [NUM_WIDTH-1:0]   dn_data,
  output logic                   err_seq,
  output logic                   err_ovf,
  input  logic                   err_clr
);

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                          done_q, done_d;
  logic                          seq_err;
  logic signed [ACC_WIDTH-1:0]   up_ext;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic        [NUM_WIDTH-1:0]   result;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          fifo_drop;

  assign up_ext = {{(ACC_WIDTH-NUM_WIDTH){up_data[NUM_WIDTH-1]}}, up_data};

  // Beat handling: start, extend, restart or drop a sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    seq_err = 1'b0;
    if (up_val) begin
      if (up_first) begin
        acc_d   = up_ext;
        shift_d = cfg_shift;
        done_d  = up_last;
        state_d = up_last ? IDLE : ACCUM;
        seq_err = (state_q == ACCUM);
      end else if (state_q == ACCUM) begin
        acc_d  = acc_q + up_ext;
        done_d = up_last;
        if (up_last) state_d = IDLE;
      end else begin
        seq_err = 1'b1;
      end
    end
  end

  // Sequence state, running sum, latched shift and final-sum marker.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign shifted = acc_q >>> shift_q;

`ifdef GROUP_ACCUM_SATURATE_EN
  logic signed [SAT_W-1:0] clamped;
  assign clamped = sat_clamp(SAT_W'(shifted), NUM_WIDTH);
  assign result  = NUM_WIDTH'(clamped);
`else
  assign result  = NUM_WIDTH'(shifted);
`endif

  // The registered final sum is pushed one cycle after the last beat.
  group_accum_fifo #(
    .WIDTH (NUM_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (done_q),
    .din   (result),
    .pop   (dn_val & dn_rdy),
    .dout  (dn_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign dn_val = ~fifo_empty;

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_seq <= seq_err   | (err_seq & ~err_clr);
      err_ovf <= fifo_drop | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_group_accum.sv
// Testbench for group_accum: directed sequences, expected results queued by
// the stimulus and compared by an independent output monitor.
module tb_group_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        up_val = 1'b0;
  logic        up_first = 1'b0;
  logic        up_last = 1'b0;
  logic [15:0] up_data = '0;
  logic        dn_val;
  logic        dn_rdy = 1'b1;
  logic [15:0] dn_data;
  logic        err_seq;
  logic        err_ovf;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  group_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_shift (cfg_shift),
    .up_val    (up_val),
    .up_first  (up_first),
    .up_last   (up_last),
    .up_data   (up_data),
    .dn_val    (dn_val),
    .dn_rdy    (dn_rdy),
    .dn_data   (dn_data),
    .err_seq   (err_seq),
    .err_ovf   (err_ovf),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit f, input bit l);
    up_val   = 1'b1;
    up_first = f;
    up_last  = l;
    up_data  = 16'(d);
    tick();
    up_val   = 1'b0;
    up_first = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || dn_val) && n < 50) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Monitor: every accepted output word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && dn_val && dn_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", $signed(dn_data), 99999);
      end else begin
        check("dn_data", $signed(dn_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_dn_val", dn_val, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_err_ovf", err_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic three-term sum with latency check.
    cfg_shift = 5'd0;
    exp_q.push_back(250);
    send(100, 1, 0);
    send(200, 0, 0);
    send(-50, 0, 1);
    check("t1_dn_val_t1", dn_val, 0);
    tick();
    check("t1_dn_val_t2", dn_val, 1);
    drain();
    check("t1_err_seq", err_seq, 0);
    check("t1_err_ovf", err_ovf, 0);

    // 2: large sum narrowed, then rescaled into range.
`ifdef GROUP_ACCUM_SATURATE_EN
    exp_q.push_back(32767);
`else
    exp_q.push_back(-11072);
`endif
    send(30000, 1, 0);
    send(30000, 0, 0);
    send(30000, 0, 0);
    send(30000, 0, 1);
    drain();
    cfg_shift = 5'd2;
    exp_q.push_back(30000);
    send(30000, 1, 0);
    send(30000, 0, 0);
    send(30000, 0, 0);
    send(30000, 0, 1);
    drain();

    // 3: single-term sequences, floor on negative shift.
    cfg_shift = 5'd1;
    exp_q.push_back(-4);
    send(-7, 1, 1);
    cfg_shift = 5'd0;
    exp_q.push_back(32767);
    send(32767, 1, 1);
    drain();

    // 4: buffer overflow with consumer stalled.
    dn_rdy = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    send(1, 1, 1);
    send(2, 1, 1);
    send(3, 1, 1);
    tick();
    tick();
    check("t4_dn_val", dn_val, 1);
    check("t4_head", $signed(dn_data), 1);
    check("t4_err_ovf", err_ovf, 1);
    check("t4_err_seq", err_seq, 0);
    dn_rdy = 1'b1;
    drain();
    check("t4_err_ovf_held", err_ovf, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_ovf_clr", err_ovf, 0);

    // 5: framing errors.
    send(77, 0, 0);
    check("t5_err_seq_idle", err_seq, 1);
    exp_q.push_back(10);
    send(5, 1, 0);
    send(9, 1, 0);
    send(1, 0, 1);
    drain();
    check("t5_err_seq", err_seq, 1);
    // A new error in the same cycle as the clear keeps the flag set.
    err_clr = 1'b1;
    send(4, 0, 0);
    err_clr = 1'b0;
    check("t5_clr_priority", err_seq, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_seq_clr", err_seq, 0);

    // 6: asynchronous reset mid-sequence with a buffered result.
    dn_rdy = 1'b0;
    exp_q.push_back(7);
    send(7, 1, 1);
    tick();
    check("t6_buffered", dn_val, 1);
    send(4, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_dn_val", dn_val, 0);
    check("t6_async_dn_data", dn_data, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    dn_rdy = 1'b1;
    tick();
    exp_q.push_back(3);
    send(3, 1, 1);
    check("t6_dn_val_t1", dn_val, 0);
    tick();
    check("t6_dn_val_t2", dn_val, 1);
    drain();
    check("t6_err_seq", err_seq, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/group_accum.md
Name: group_accum

Overview:
- Sits directly downstream of the group adder tree.
- Accumulates its per-cycle signed partial sums over a framed sequence (one output pixel across kernel positions and input channel groups).
- Rescales each final sum by a configurable arithmetic right shift and narrows it to NUM_WIDTH.
- Presents results through a 2-entry valid/ready output buffer, because the upstream adder pipeline has no backpressure.

Parameters:
- NUM_WIDTH, 16, width of signed input samples and of the output result.
- ACC_WIDTH, 32, width of the internal signed accumulator; must be at least NUM_WIDTH+1.
- SHIFT_WIDTH, 5, width of cfg_shift.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_shift  in  SHIFT_WIDTH  arithmetic right shift applied to the final sum; sampled on the up_first beat.
- up_val  in  1  up_data/flags valid this cycle.
- up_first  in  1  first term of a sequence (qualified by up_val).
- up_last  in  1  last term of a sequence (qualified by up_val).
- up_data  in  NUM_WIDTH  signed partial sum from the adder tree.
- dn_val  out  1  output buffer non-empty.
- dn_rdy  in  1  consumer accepts when dn_val&dn_rdy.
- dn_data  out  NUM_WIDTH  signed rescaled result, head of buffer.
- err_seq  out  1  sticky framing error.
- err_ovf  out  1  sticky output-buffer overflow (result dropped).
- err_clr  in  1  synchronous clear of both error flags.

Behaviour:
- Reset (async assert, sync release): state IDLE, accumulator 0, buffer empty, dn_val 0, dn_data 0, err_seq 0, err_ovf 0. Reset mid-sequence discards the partial sum and all buffered results.
- States: IDLE and ACCUM.
- Beat handling (only when up_val=1):
  - up_first in either state: acc <= sign-extended up_data; shift latched.
    - In ACCUM this restarts the sequence, discards the old partial sum and sets err_seq.
  - Non-first beat in ACCUM: acc <= acc + up_data, wrapping modulo 2^ACC_WIDTH.
  - Non-first beat in IDLE: dropped; err_seq set.
  - up_last on an accepted beat: the beat's contribution is included; the state returns to IDLE.
  - up_first and up_last together: single-term sequence.
- A beat with up_first or up_last sets the state to ACCUM if up_last=0, IDLE if up_last=1.
- Back-to-back sequences with no idle cycle are supported.
- Result latency: up_last beat at cycle t → final sum registered at t+1 → rescaled value written into the buffer at the t+1→t+2 edge; dn_val is high at t+2 if the buffer was empty.
- Rescale: arithmetic right shift by the latched shift (floor toward −inf, no rounding), then narrow to NUM_WIDTH per the optional feature.
- Output buffer: 2-entry FIFO.
  - Push when full and no pop in the same cycle: result dropped, err_ovf set.
  - Push and pop in the same cycle when full: both occur, nothing dropped.
  - Results leave in order. dn_data is stable while dn_val&!dn_rdy.
- Error flags:
  - err_clr clears both flags.
  - A new error in the same cycle as err_clr takes priority: the flag stays 1.

Optional Feature:
- Macro: GROUP_ACCUM_SATURATE_EN.
- Defined: the shifted value is clamped to [−2^(NUM_WIDTH−1), 2^(NUM_WIDTH−1)−1].
- Undefined: the low NUM_WIDTH bits are taken (two's-complement wrap).
- Latency is identical in both builds.

Decomposition:
- Shared package: the IDLE/ACCUM state encoding and the saturation helper function (min/max constants derived from NUM_WIDTH).
- One natural sub-module: group_accum_fifo (2-entry synchronous FIFO, parameterised width, async active-low reset, full/empty, same-cycle push/pop when full).

Test Plan:
1. shift=0; beats 100(first), 200, −50(last) → dn_data=250, dn_val rises two cycles after the last beat; err flags stay 0.
2. Four beats of 30000, shift=0 → saturate build: 32767; wrap build: −11072 (0xD4C0). Same beats, shift=2 → 30000 in both builds.
3. Single beat first&last −7, shift=1 → −4 (floor); single beat 0x7FFF, shift=0 → 32767.
4. dn_rdy=0, three one-beat sequences (1, 2, 3) → buffer holds 1 and 2, third dropped, err_ovf=1; raise dn_rdy → 1 then 2 delivered; err_clr → err_ovf=0.
5. Framing: up_val beat without up_first in IDLE → dropped, err_seq=1. Then first=5, first=9, last=1 → only 10 output.
6. rst_n low mid-sequence with one buffered result → dn_val 0 immediately (async). After release, a new sequence 3(first&last) → dn_data=3 at t+2.
